fpnew_slice_share_arb: RTL and testbench
========================================

# fpnew_slice_share_arb

Round-robin arbiter that lets `NumPorts` independent requesters share one operation-group format slice (FMA, NONCOMP, …). It sits between the requesters and the slice's input and output handshakes. It adds no latency, keeps the slice pipeline full, and returns each result to the port that issued it. Issue order is recorded in an internal ID FIFO, so the slice needs no knowledge of requesters.

## Interface
- `NumPorts`, 2: number of requesters, ≥2.
- `MaxOutstanding`, 4: depth of the ID FIFO. Must be ≥ slice pipeline depth + 1 for full throughput.
- `ReqType`, logic: packed request payload (operands, is_boxed, rnd_mode, op, op_mod, vectorial_op, tag), passed through unmodified.
- `RspType`, logic: packed response payload (result, status, extension_bit, tag), passed through unmodified.
- Derived: `IdxWidth` = max(1, $clog2(NumPorts)); `CntWidth` = $clog2(MaxOutstanding+1).
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `req_valid_i` in NumPorts: per-port request valid.
- `req_ready_o` out NumPorts: per-port request ready.
- `req_i` in NumPorts×ReqType: per-port request payload.
- `slice_valid_o` out 1: valid to the slice `in_valid_i`.
- `slice_ready_i` in 1: from the slice `in_ready_o`.
- `slice_req_o` out ReqType: payload of the granted port.
- `slice_out_valid_i` in 1: from the slice `out_valid_o`.
- `slice_out_ready_o` out 1: to the slice `out_ready_i`.
- `slice_rsp_i` in RspType: slice result payload.
- `rsp_valid_o` out NumPorts: per-port response valid, one-hot or zero.
- `rsp_ready_i` in NumPorts: per-port response ready.
- `rsp_o` out RspType: response payload, broadcast to all ports (equals `slice_rsp_i`).
- `flush_i` in 1: kill all in-flight operations.
- `slice_flush_o` out 1: equals `flush_i`.
- `slice_busy_i` in 1: the slice `busy_o`.
- `busy_o` out 1: arbiter or slice holds work.

## Operation
**State**
- `rr_ptr` (IdxWidth): round-robin pointer.
- `lock_q` / `lock_idx_q`: stability lock and the port it holds.
- ID FIFO of port indices, `MaxOutstanding` deep, with occupancy counter `cnt` (CntWidth).

**Arbitration**
- With `lock_q`=0, grant the first port with `req_valid_i` set, searching `rr_ptr`, `rr_ptr`+1, … modulo NumPorts.
- With `lock_q`=1, the grant is forced to `lock_idx_q`.
- `slice_valid_o` = any grant & !full & !`flush_i`.
- `slice_req_o` = `req_i[grant]`.
- `req_ready_o[i]` = grant==i & `slice_ready_i` & !full & !`flush_i`.

**Stability lock**
- When `slice_valid_o`=1 and `slice_ready_i`=0, set `lock_q`=1 and `lock_idx_q`=grant.
- Clear the lock on issue or on flush.
- A requester must hold `req_valid_i` and `req_i` stable until its ready is seen.

**Issue** (`slice_valid_o` & `slice_ready_i`)
- Push the grant index into the FIFO.
- `rr_ptr` ← grant+1, wrapping from NumPorts-1 to 0.

**Full**
- `cnt`==MaxOutstanding blocks issue, even if a pop happens in the same cycle.
- Full never produces a half-handshake.

**Response routing** (head = FIFO head index)
- `rsp_valid_o[head]` = `slice_out_valid_i` & !empty & !`flush_i`.
- `slice_out_ready_o` = `rsp_ready_i[head]` & !empty & !`flush_i`.
- A response handshake pops the FIFO.
- Push and pop in the same cycle leave `cnt` unchanged.

**Empty FIFO**
- If `slice_out_valid_i` rises while the FIFO is empty, hold `slice_out_ready_o`=0 and `rsp_valid_o`=0.
- This is a protocol error and fires an assertion.

**Flush**
- Combinationally: all `req_ready_o`=0, `slice_valid_o`=0, `rsp_valid_o`=0, `slice_out_ready_o`=0.
- Next edge: FIFO empty, `cnt`=0, `lock_q`=0; `rr_ptr` is kept.

**busy_o** = `slice_busy_i` | (`cnt`≠0) | `lock_q`.

## Timing
- Arbitration and issue are combinational, adding 0 cycles of latency. Sustained throughput is 1 issue per cycle.
- Combinational paths exist from `slice_ready_i` to `req_ready_o`, and from `rsp_ready_i` to `slice_out_ready_o`.
- Registered outputs: none. All outputs derive from state plus inputs.
- After reset: `rr_ptr`=0, FIFO empty, `lock_q`=0.
  - With inputs idle, `slice_valid_o`=0, `req_ready_o`=0, `rsp_valid_o`=0, `slice_out_ready_o`=0, and `busy_o`=`slice_busy_i`.
- Reset asserted mid-operation: all state clears asynchronously. In-flight slice results must be flushed by the integrator with `flush_i` or by the slice's own reset.
- `flush_i` takes priority over a simultaneous issue or response in the same cycle.

## Test plan
1. **Round-robin fairness.** NumPorts=2, both ports valid for 4 cycles, `slice_ready_i`=1 → issue order 0,1,0,1; `rr_ptr` is 0 at the end; 4 FIFO pushes.
2. **Stall lock.** Port 1 valid at cycle 0 with `slice_ready_i`=0 for 3 cycles; port 0 raises valid at cycle 1 → grant stays 1 and `slice_req_o` is stable. At `slice_ready_i`=1 port 1 issues, then port 0 issues next.
3. **Routing under reorder pressure.** Issue ports 1,0,1 into a 2-cycle slice → `rsp_valid_o` one-hot sequence 2'b10, 2'b01, 2'b10.
   - Hold `rsp_ready_i[0]`=0 for 2 cycles → `slice_out_ready_o`=0 for those 2 cycles, with no pop.
4. **Full.** MaxOutstanding=4, `slice_out_ready_o` blocked, 5 requests → exactly 4 issue, `cnt`=4, the 5th sees `req_ready_o`=0.
   - In the cycle of the first pop, issue stays blocked. The following cycle it issues.
5. **Flush.** Flush with `cnt`=3 and a port valid → that cycle: `slice_flush_o`=1 and no handshakes. Next cycle: `cnt`=0, `busy_o`=`slice_busy_i`, `rr_ptr` unchanged.
6. **Async reset.** Assert `rst_ni`=0 mid-burst with `cnt`=2 → `cnt`=0, `rr_ptr`=0 and `lock_q`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fpnew_slice_share_arb.sv
// Round-robin sharing of one operation-group format slice between NumPorts requesters.
// Issue order is kept in an ID FIFO so results are routed back to the issuing port.
module fpnew_slice_share_arb #(
    parameter int unsigned NumPorts       = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         ReqType        = logic,
    parameter type         RspType        = logic
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumPorts-1:0]   req_valid_i,
    output logic [NumPorts-1:0]   req_ready_o,
    input  ReqType [NumPorts-1:0] req_i,
    output logic                  slice_valid_o,
    input  logic                  slice_ready_i,
    output ReqType                slice_req_o,
    input  logic                  slice_out_valid_i,
    output logic                  slice_out_ready_o,
    input  RspType                slice_rsp_i,
    output logic [NumPorts-1:0]   rsp_valid_o,
    input  logic [NumPorts-1:0]   rsp_ready_i,
    output RspType                rsp_o,
    input  logic                  flush_i,
    output logic                  slice_flush_o,
    input  logic                  slice_busy_i,
    output logic                  busy_o
);

    localparam int unsigned IdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [IdxWidth-1:0] rr_ptr, lock_idx_q, gnt_idx, head_idx, scan_idx, rr_next;
    logic                lock_q, gnt_valid, full, empty, issue, pop;
    logic [CntWidth-1:0] cnt;
    logic [PtrWidth-1:0] wr_ptr, rd_ptr;
    logic [IdxWidth-1:0] id_fifo [MaxOutstanding];

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // Scan from the highest offset down so the port nearest rr_ptr wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = rr_ptr;
        scan_idx  = '0;
        if (lock_q) begin
            gnt_valid = req_valid_i[lock_idx_q];
            gnt_idx   = lock_idx_q;
        end else begin
            for (int k = int'(NumPorts) - 1; k >= 0; k--) begin
                scan_idx = IdxWidth'((int'(rr_ptr) + k) % int'(NumPorts));
                if (req_valid_i[scan_idx]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = scan_idx;
                end
            end
        end
    end

    assign rr_next = (gnt_idx == IdxWidth'(NumPorts - 1)) ? '0 : gnt_idx + 1'b1;

    assign full          = (cnt == CntWidth'(MaxOutstanding));
    assign empty         = (cnt == '0);
    assign slice_valid_o = gnt_valid & ~full & ~flush_i;
    assign issue         = slice_valid_o & slice_ready_i;
    assign slice_req_o   = req_i[gnt_idx];

    always_comb begin
        req_ready_o = '0;
        if (gnt_valid && slice_ready_i && !full && !flush_i) req_ready_o[gnt_idx] = 1'b1;
    end

    assign head_idx          = id_fifo[rd_ptr];
    assign slice_out_ready_o = rsp_ready_i[head_idx] & ~empty & ~flush_i;
    assign pop               = slice_out_valid_i & slice_out_ready_o;
    assign rsp_o             = slice_rsp_i;
    assign slice_flush_o     = flush_i;
    assign busy_o            = slice_busy_i | (cnt != '0) | lock_q;

    always_comb begin
        rsp_valid_o = '0;
        if (slice_out_valid_i && !empty && !flush_i) rsp_valid_o[head_idx] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr     <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            cnt        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else if (flush_i) begin
            lock_q <= 1'b0;
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (issue) begin
                rr_ptr <= rr_next;
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (issue && !pop) cnt <= cnt + 1'b1;
            else if (pop && !issue) cnt <= cnt - 1'b1;
            // A stalled offer pins the grant so the slice sees a stable payload.
            if (issue) begin
                lock_q <= 1'b0;
            end else if (slice_valid_o) begin
                lock_q     <= 1'b1;
                lock_idx_q <= gnt_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (issue) id_fifo[wr_ptr] <= gnt_idx;
    end

    // A slice result with no outstanding issue means the slice broke protocol.
    rsp_without_issue: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(slice_out_valid_i && empty && !flush_i));

endmodule

// File: tb/tb_fpnew_slice_share_arb.sv
// Directed bench for fpnew_slice_share_arb: two ports, four outstanding IDs.
module tb_fpnew_slice_share_arb;
    typedef logic [7:0] req_t;
    typedef logic [7:0] rsp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    req_t [1:0] req_d;
    req_t       slice_req;
    rsp_t       slice_rsp, rsp_d;
    logic       slice_valid, slice_ready, slice_out_valid, slice_out_ready;
    logic       flush, slice_flush, slice_busy, busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpnew_slice_share_arb #(
        .NumPorts(2), .MaxOutstanding(4), .ReqType(req_t), .RspType(rsp_t)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_i(req_d),
        .slice_valid_o(slice_valid), .slice_ready_i(slice_ready), .slice_req_o(slice_req),
        .slice_out_valid_i(slice_out_valid), .slice_out_ready_o(slice_out_ready),
        .slice_rsp_i(slice_rsp), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_o(rsp_d), .flush_i(flush), .slice_flush_o(slice_flush),
        .slice_busy_i(slice_busy), .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0; slice_ready = 1'b0;
        slice_out_valid = 1'b0; flush = 1'b0; slice_busy = 1'b1;
        req_d[0] = 8'hA0; req_d[1] = 8'hA1; slice_rsp = 8'h5C;

        #2;
        chk("rst_busy", 32'(busy), 1);
        chk("rst_svalid", 32'(slice_valid), 0);
        chk("rst_rready", 32'(req_ready), 0);
        chk("rst_rspv", 32'(rsp_valid), 0);
        chk("rst_soready", 32'(slice_out_ready), 0);
        chk("rst_cnt", 32'(dut.cnt), 0);
        tick();
        rst_n = 1'b1; slice_busy = 1'b0;
        #1 chk("idle_busy", 32'(busy), 0);
        tick();

        // round robin with both ports requesting
        req_valid = 2'b11; slice_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_req", 32'(slice_req), i[0] ? 'hA1 : 'hA0);
            chk("rr_ready", 32'(req_ready), i[0] ? 2 : 1);
            tick();
        end
        chk("rr_cnt", 32'(dut.cnt), 4);
        chk("rr_ptr_end", 32'(dut.rr_ptr), 0);

        // FIFO full blocks a fifth request, even in the cycle of a pop
        req_valid = 2'b01;
        #1;
        chk("full_svalid", 32'(slice_valid), 0);
        chk("full_rready", 32'(req_ready), 0);
        tick();
        chk("full_cnt", 32'(dut.cnt), 4);
        slice_out_valid = 1'b1; rsp_ready = 2'b11;
        #1;
        chk("pop_rspv", 32'(rsp_valid), 1);
        chk("pop_soready", 32'(slice_out_ready), 1);
        chk("pop_rsp", 32'(rsp_d), 'h5C);
        chk("pop_svalid", 32'(slice_valid), 0);
        chk("pop_rready", 32'(req_ready), 0);
        tick();
        slice_out_valid = 1'b0;
        #1;
        chk("after_pop_cnt", 32'(dut.cnt), 3);
        chk("after_pop_rready", 32'(req_ready), 1);
        chk("after_pop_svalid", 32'(slice_valid), 1);
        tick();
        req_valid = 2'b00;
        chk("refill_cnt", 32'(dut.cnt), 4);

        // drain FIFO holding ports 1,0,1,0 with a back-pressure window on port 0
        slice_out_valid = 1'b1; rsp_ready = 2'b11;
        #1 chk("route_a", 32'(rsp_valid), 2);
        tick();
        rsp_ready = 2'b10;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("hold_rspv", 32'(rsp_valid), 1);
            chk("hold_soready", 32'(slice_out_ready), 0);
            tick();
        end
        chk("hold_cnt", 32'(dut.cnt), 3);
        rsp_ready = 2'b11;
        #1 chk("route_b", 32'(rsp_valid), 1);
        tick();
        #1 chk("route_c", 32'(rsp_valid), 2);
        tick();
        #1 chk("route_d", 32'(rsp_valid), 1);
        tick();
        slice_out_valid = 1'b0;
        #1;
        chk("drain_cnt", 32'(dut.cnt), 0);
        chk("drain_ptr", 32'(dut.rr_ptr), 1);

        // flush with three in flight and a port requesting
        req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1 chk("fl_fill", 32'(req_ready), 1);
            tick();
        end
        chk("fl_pre_cnt", 32'(dut.cnt), 3);
        flush = 1'b1; slice_out_valid = 1'b1; slice_busy = 1'b1;
        #1;
        chk("fl_sflush", 32'(slice_flush), 1);
        chk("fl_svalid", 32'(slice_valid), 0);
        chk("fl_rready", 32'(req_ready), 0);
        chk("fl_rspv", 32'(rsp_valid), 0);
        chk("fl_soready", 32'(slice_out_ready), 0);
        tick();
        flush = 1'b0; slice_out_valid = 1'b0; req_valid = 2'b00;
        #1;
        chk("fl_cnt", 32'(dut.cnt), 0);
        chk("fl_ptr", 32'(dut.rr_ptr), 1);
        chk("fl_busy1", 32'(busy), 1);
        slice_busy = 1'b0;
        #1 chk("fl_busy0", 32'(busy), 0);

        // asynchronous reset with two in flight and a held lock
        req_valid = 2'b11;
        #1 chk("ar_g1", 32'(req_ready), 2);
        tick();
        #1 chk("ar_g0", 32'(req_ready), 1);
        tick();
        slice_ready = 1'b0;
        tick();
        chk("ar_lock", 32'(dut.lock_q), 1);
        chk("ar_cnt", 32'(dut.cnt), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_cnt0", 32'(dut.cnt), 0);
        chk("ar_ptr0", 32'(dut.rr_ptr), 0);
        chk("ar_lock0", 32'(dut.lock_q), 0);
        req_valid = 2'b00;
        #1 rst_n = 1'b1;
        tick();

        // stall lock keeps port 1 granted after port 0 appears
        req_valid = 2'b10;
        #1;
        chk("lk_req", 32'(slice_req), 'hA1);
        chk("lk_svalid", 32'(slice_valid), 1);
        chk("lk_rready", 32'(req_ready), 0);
        tick();
        req_valid = 2'b11;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lk_held", 32'(dut.lock_q), 1);
            chk("lk_stable", 32'(slice_req), 'hA1);
            tick();
        end
        slice_ready = 1'b1;
        #1 chk("lk_issue1", 32'(req_ready), 2);
        tick();
        req_valid = 2'b01;
        #1;
        chk("lk_issue0", 32'(req_ready), 1);
        chk("lk_req0", 32'(slice_req), 'hA0);
        tick();
        req_valid = 2'b00; slice_ready = 1'b0;
        chk("lk_cnt", 32'(dut.cnt), 2);
        slice_out_valid = 1'b1;
        #1 chk("lk_route1", 32'(rsp_valid), 2);
        tick();
        #1 chk("lk_route0", 32'(rsp_valid), 1);
        tick();
        slice_out_valid = 1'b0;
        #1;
        chk("end_cnt", 32'(dut.cnt), 0);
        chk("end_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
